switch_debouncer: RTL and testbench

- Upstream conditioner for the `switch[7:0]` input of the memory-mapped peripheral block.
- Synchronises raw board switches into the `clk` domain and debounces each bit independently.
- Drives the stable vector that software reads at 0x40000014.
- Also emits per-bit rise/fall pulses and an any-change pulse, for a future switch-interrupt source.

---
 rtl/switch_debouncer_if.sv | 27 ++
 rtl/switch_debouncer.sv | 85 ++++++++
 tb/tb_switch_debouncer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_debouncer_if.sv
// Switch conditioner bundle: raw pin levels in, debounced levels and edge pulses out.
// The master side is the debouncer; the slave side is the consuming peripheral.
interface switch_debouncer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] switch_raw;
  logic [WIDTH-1:0] switch_db;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             change;

  modport master (
    input  switch_raw,
    output switch_db,
    output rise,
    output fall,
    output change
  );

  modport slave (
    output switch_raw,
    input  switch_db,
    input  rise,
    input  fall,
    input  change
  );
endinterface

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus independent per-bit debounce counters for board switches.
// Emits registered debounced levels and one-cycle rise/fall/change pulses.
module switch_debouncer #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 20
) (
  input  logic              clk,
  input  logic              reset,
  switch_debouncer_if.master sw
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] db_reg;
  logic [WIDTH-1:0] db_next;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;
  logic             change_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sw.switch_raw;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] cnt_next;
      logic                 db_bit_next;

      // Any cycle agreeing with the accepted level discards a partial count.
      always_comb begin
        cnt_next    = '0;
        db_bit_next = db_reg[gi];
        if (sync2_reg[gi] != db_reg[gi]) begin
          if (cnt_reg == CNT_LAST) begin
            db_bit_next = sync2_reg[gi];
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign db_next[gi] = db_bit_next;
    end
  endgenerate

  // Pulses are registered alongside the level so they coincide with its first visible cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_reg     <= '0;
      rise_reg   <= '0;
      fall_reg   <= '0;
      change_reg <= 1'b0;
    end else begin
      db_reg     <= db_next;
      rise_reg   <= db_next & ~db_reg;
      fall_reg   <= ~db_next & db_reg;
      change_reg <= |(db_next ^ db_reg);
    end
  end

  assign sw.switch_db = db_reg;
  assign sw.rise      = rise_reg;
  assign sw.fall      = fall_reg;
  assign sw.change    = change_reg;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: two instances (4-cycle and 1-cycle qualification) checked every
// cycle against a window-over-history model, plus hand-computed checkpoints.
module tb_switch_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] raw4 = 8'h00;
  logic [7:0] raw1 = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  switch_debouncer_if #(.WIDTH(8)) sw4 ();
  switch_debouncer_if #(.WIDTH(8)) sw1 ();

  assign sw4.switch_raw = raw4;
  assign sw1.switch_raw = raw1;

  switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(4), .CNT_WIDTH(20)) dut4 (
    .clk   (clk),
    .reset (reset),
    .sw    (sw4.master)
  );

  switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(1), .CNT_WIDTH(20)) dut1 (
    .clk   (clk),
    .reset (reset),
    .sw    (sw1.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a bit flips once the last S levels seen by the debouncer, all taken
  // since the last reset, disagree with its accepted level. The level seen at
  // edge n is the raw sample of edge n-2, or 0 if reset was active at n-1 or n-2.
  function automatic int s_of(input int j);
    return (j == 0) ? 4 : 1;
  endfunction

  logic [7:0] masked_m1 [2];
  logic [7:0] masked_m2 [2];
  logic [7:0] seen_hist [2][8];
  int         valid_edges [2];
  logic       rst_prev = 1'b0;
  logic       model_live = 1'b0;
  logic [7:0] m_db   [2];
  logic [7:0] m_rise [2];
  logic [7:0] m_fall [2];
  logic       m_change [2];

  initial begin
    for (int j = 0; j < 2; j++) begin
      masked_m1[j] = '0; masked_m2[j] = '0; valid_edges[j] = 0;
      m_db[j] = '0; m_rise[j] = '0; m_fall[j] = '0; m_change[j] = 1'b0;
      for (int k = 0; k < 8; k++) seen_hist[j][k] = '0;
    end
  end

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      logic [7:0] raw_now, seen, old_db, new_db;
      raw_now = (j == 0) ? raw4 : raw1;
      if (reset) begin
        valid_edges[j] = 0;
        m_db[j] = '0; m_rise[j] = '0; m_fall[j] = '0; m_change[j] = 1'b0;
      end else begin
        seen = rst_prev ? 8'h00 : masked_m2[j];
        for (int k = 7; k > 0; k--) seen_hist[j][k] = seen_hist[j][k-1];
        seen_hist[j][0] = seen;
        if (valid_edges[j] < 100) valid_edges[j]++;
        old_db = m_db[j];
        new_db = old_db;
        for (int b = 0; b < 8; b++) begin
          if (valid_edges[j] >= s_of(j)) begin
            logic all_differ;
            all_differ = 1'b1;
            for (int k = 0; k < s_of(j); k++)
              if (seen_hist[j][k][b] == old_db[b]) all_differ = 1'b0;
            if (all_differ) new_db[b] = ~old_db[b];
          end
        end
        m_db[j]     = new_db;
        m_rise[j]   = new_db & ~old_db;
        m_fall[j]   = ~new_db & old_db;
        m_change[j] = (new_db != old_db);
      end
      masked_m2[j] = masked_m1[j];
      masked_m1[j] = reset ? 8'h00 : raw_now;
    end
    rst_prev = reset;
    if (reset) model_live = 1'b1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_live) begin
      check("s4_db",     {24'h0, sw4.switch_db}, {24'h0, m_db[0]});
      check("s4_rise",   {24'h0, sw4.rise},      {24'h0, m_rise[0]});
      check("s4_fall",   {24'h0, sw4.fall},      {24'h0, m_fall[0]});
      check("s4_change", {31'h0, sw4.change},    {31'h0, m_change[0]});
      check("s1_db",     {24'h0, sw1.switch_db}, {24'h0, m_db[1]});
      check("s1_rise",   {24'h0, sw1.rise},      {24'h0, m_rise[1]});
      check("s1_fall",   {24'h0, sw1.fall},      {24'h0, m_fall[1]});
      check("s1_change", {31'h0, sw1.change},    {31'h0, m_change[1]});
    end
  end

  // Pulse monitors used by the directed checkpoints.
  int   pulses4 = 0;
  int   pulses1_b3 = 0;
  int   consec_b3 = 0;
  logic prev_b3 = 1'b0;
  always @(negedge clk) begin
    logic cur_b3;
    if (sw4.change) pulses4++;
    cur_b3 = sw1.rise[3] | sw1.fall[3];
    if (cur_b3) pulses1_b3++;
    if (cur_b3 && prev_b3) consec_b3++;
    prev_b3 = cur_b3;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    step(1);
    check("rst_db4", {24'h0, sw4.switch_db}, 32'h0);
    check("rst_chg4", {31'h0, sw4.change}, 32'h0);
    check("rst_db1", {24'h0, sw1.switch_db}, 32'h0);
    step(2);
    reset = 1'b0;
    step(3);
    $display("reset released, outputs idle");

    // Single bit rise, 4-cycle qualification
    raw4 = 8'h01;
    step(5);
    check("t1_db_k4", {24'h0, sw4.switch_db}, 32'h00);
    step(1);
    check("t1_db_k5", {24'h0, sw4.switch_db}, 32'h01);
    check("t1_rise", {24'h0, sw4.rise}, 32'h01);
    check("t1_fall", {24'h0, sw4.fall}, 32'h00);
    check("t1_change", {31'h0, sw4.change}, 32'h1);
    step(1);
    check("t1_rise_off", {24'h0, sw4.rise}, 32'h00);
    $display("t1 rise transaction done");

    // Glitch of 3 cycles is rejected, 6 cycles is accepted
    base = pulses4;
    raw4 = 8'h00;
    step(3);
    raw4 = 8'h01;
    step(8);
    check("t2_glitch_db", {24'h0, sw4.switch_db}, 32'h01);
    check("t2_glitch_pulses", pulses4, base);
    raw4 = 8'h00;
    step(5);
    check("t2_db_k4", {24'h0, sw4.switch_db}, 32'h01);
    step(1);
    check("t2_db_k5", {24'h0, sw4.switch_db}, 32'h00);
    check("t2_fall", {24'h0, sw4.fall}, 32'h01);
    step(1);
    check("t2_fall_off", {24'h0, sw4.fall}, 32'h00);
    $display("t2 glitch/fall transaction done");

    // Multi-bit simultaneous transitions
    raw4 = 8'hA5;
    step(5);
    check("t3a_db_k4", {24'h0, sw4.switch_db}, 32'h00);
    step(1);
    check("t3a_db", {24'h0, sw4.switch_db}, 32'hA5);
    check("t3a_rise", {24'h0, sw4.rise}, 32'hA5);
    check("t3a_change", {31'h0, sw4.change}, 32'h1);
    step(2);
    raw4 = 8'h5A;
    step(5);
    check("t3b_db_k4", {24'h0, sw4.switch_db}, 32'hA5);
    step(1);
    check("t3b_db", {24'h0, sw4.switch_db}, 32'h5A);
    check("t3b_rise", {24'h0, sw4.rise}, 32'h5A);
    check("t3b_fall", {24'h0, sw4.fall}, 32'hA5);
    step(1);
    check("t3b_change_off", {31'h0, sw4.change}, 32'h0);
    $display("t3 multi-bit transactions done");

    // Reset mid-count with all switches high
    raw4 = 8'hFF;
    step(4);
    base = pulses4;
    reset = 1'b1;
    step(1);
    check("t4_rst_db", {24'h0, sw4.switch_db}, 32'h00);
    check("t4_rst_change", {31'h0, sw4.change}, 32'h0);
    reset = 1'b0;
    step(5);
    check("t4_db_early", {24'h0, sw4.switch_db}, 32'h00);
    check("t4_no_pulse", pulses4, base);
    step(1);
    check("t4_db", {24'h0, sw4.switch_db}, 32'hFF);
    check("t4_rise", {24'h0, sw4.rise}, 32'hFF);
    step(1);
    check("t4_single_pulse", pulses4, base + 1);
    $display("t4 reset-mid-count transaction done");

    // One-cycle qualification: bit3 toggles every 3 cycles
    base = pulses1_b3;
    for (int t = 0; t < 8; t++) begin
      raw1 = raw1 ^ 8'h08;
      step(2);
      check("t5_db_hold", {31'h0, sw1.switch_db[3]}, {31'h0, ~raw1[3]});
      step(1);
      check("t5_db_new", {31'h0, sw1.switch_db[3]}, {31'h0, raw1[3]});
      check("t5_pulse", {30'h0, sw1.rise[3], sw1.fall[3]}, raw1[3] ? 32'h2 : 32'h1);
    end
    step(2);
    check("t5_pulse_count", pulses1_b3, base + 8);
    check("t5_no_consec", consec_b3, 0);
    $display("t5 toggle transactions done");

    // Bouncing bit7: short high bursts never qualify, then it settles high
    raw4 = 8'h00;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(3);
    base = pulses4;
    for (int t = 0; t < 150; t++) begin
      raw4 = 8'h80;
      step($urandom_range(1, 3));
      raw4 = 8'h00;
      step($urandom_range(1, 3));
    end
    check("t6_bounce_db", {24'h0, sw4.switch_db}, 32'h00);
    check("t6_bounce_pulses", pulses4, base);
    raw4 = 8'h80;
    step(5);
    check("t6_db_k4", {24'h0, sw4.switch_db}, 32'h00);
    step(1);
    check("t6_db", {24'h0, sw4.switch_db}, 32'h80);
    check("t6_rise", {24'h0, sw4.rise}, 32'h80);
    step(3);
    $display("t6 bounce transaction done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
